rx_channel_init: RTL and testbench
==================================

RX_CHANNEL_INIT -- requirements
Module: rx_channel_init

Interface
REQ-001 Parameter ALIGN_CNT, default 8: consecutive error-free non-data ordered sets needed for lane alignment.
REQ-002 Parameter VERIFY_CNT, default 4: consecutive /V/ sets needed to complete verification.
REQ-003 Parameter ERR_LIMIT, default 4: accumulated code errors in READY that force re-initialisation.
REQ-004 Parameter ERR_WINDOW, default 64: error-free valid words that clear the READY error count.
REQ-005 Parameter WATCHDOG, default 1024: cycles allowed in BONDING or VERIFICATION before restart.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 rx_os_valid  in  1  rx_os/rx_code_err qualify this cycle.
REQ-010 rx_os  in  3  received word class: 0 DATA, 1 /K/ idle-comma, 2 /A/, 3 /V/, 4 /R/, 5-7 invalid.
REQ-011 rx_code_err  in  1  8b10b decode/disparity error on this word.
REQ-012 rx_aligned  out  1  simplex sideband: lane aligned.
REQ-013 rx_bonded  out  1  simplex sideband: channel bonded.
REQ-014 rx_verified  out  1  simplex sideband: verification complete.
REQ-015 channel_up  out  1  channel ready for data.
REQ-016 state  out  3  current state encoding, debug.

Function
REQ-017 States SHALL be RESET=0, INIT=1, BONDING=2, VERIFICATION=3, READY=4; all outputs SHALL be registered.
REQ-018 A "good set" SHALL be rx_os_valid=1, rx_code_err=0, rx_os in 1..4; a "bad word" SHALL be rx_os_valid=1 with rx_code_err=1 or rx_os in 5..7.
REQ-019 rx_code_err SHALL take precedence: a word with rx_code_err=1 is treated only as a bad word regardless of rx_os.
REQ-020 Cycles with rx_os_valid=0 SHALL not change any word counter; the watchdog SHALL still advance.
REQ-021 RESET SHALL move to INIT on the first clock edge after rst deasserts.
REQ-022 INIT: align counter increments on good set, clears on bad word or DATA; on reaching ALIGN_CNT go to BONDING, rx_aligned=1 from the next cycle.
REQ-023 BONDING: first good /A/ moves to VERIFICATION with rx_bonded=1; a bad word or DATA returns to INIT.
REQ-024 VERIFICATION: verify counter increments on good /V/, is held on good /K/ or /R/, clears on /A/; on reaching VERIFY_CNT go to READY with rx_verified=1 and channel_up=1 from the next cycle.
REQ-025 VERIFICATION: bad word or DATA SHALL return to INIT.
REQ-026 Watchdog counter SHALL clear on every state change and on every counter increment in BONDING/VERIFICATION; reaching WATCHDOG in those states SHALL return to INIT.
REQ-027 READY: error counter saturating-increments on each bad word; clean counter increments on each non-bad valid word (DATA included) and clears on bad word.
REQ-028 READY: clean counter reaching ERR_WINDOW SHALL clear both counters.
REQ-029 READY: error counter reaching ERR_LIMIT SHALL return to INIT; channel_up and all sideband outputs drop the next cycle.
REQ-030 Any entry to INIT SHALL clear rx_aligned, rx_bonded, rx_verified, channel_up and all counters in the same edge.
REQ-031 Counter widths SHALL be $clog2(param+1); no counter shall wrap.

Reset
REQ-032 While rst=1: state=RESET, all outputs 0, all counters 0, regardless of clk.
REQ-033 rst asserted mid-operation (any state) SHALL clear all outputs immediately (asynchronously).

Verification
REQ-034 Reset release, 8 good /K/, one /A/, 4 /V/ -> rx_aligned after 8th /K/+1, rx_bonded after /A/+1, channel_up after 4th /V/+1; state sequence 0,1,2,3,4.
REQ-035 INIT: 5 /K/, one rx_code_err, 8 /K/ -> rx_aligned asserted only after the 8 trailing /K/.
REQ-036 VERIFICATION: /V/,/V/,/K/,/V/,/V/ -> READY (hold on /K/); /V/,/V/,/A/,/V/ -> still VERIFICATION, count=1.
REQ-037 READY: 4 bad words separated by 10 DATA each -> INIT, channel_up=0 next cycle; 3 bad words, 64 clean DATA, 3 bad words -> stays READY.
REQ-038 BONDING with rx_os_valid=0 for 1024 cycles -> INIT, rx_aligned=0.
REQ-039 rst pulsed in READY between edges -> channel_up=0 without waiting for clk; state=INIT one edge after release.

Source files
------------

// File: rtl/rx_channel_init_if.sv
// Receive-word and status bundle between the lane decoder and the channel
// initialisation block.
interface rx_channel_init_if;
    logic       rx_os_valid;
    logic [2:0] rx_os;
    logic       rx_code_err;
    logic       rx_aligned;
    logic       rx_bonded;
    logic       rx_verified;
    logic       channel_up;
    logic [2:0] state;

    modport master (
        output rx_os_valid, rx_os, rx_code_err,
        input  rx_aligned, rx_bonded, rx_verified, channel_up, state
    );

    modport slave (
        input  rx_os_valid, rx_os, rx_code_err,
        output rx_aligned, rx_bonded, rx_verified, channel_up, state
    );
endinterface

// File: rtl/rx_channel_init.sv
// Receive channel initialisation: lane alignment, bonding and verification,
// followed by error-rate monitoring while the channel is up.
module rx_channel_init #(
    parameter int ALIGN_CNT  = 8,
    parameter int VERIFY_CNT = 4,
    parameter int ERR_LIMIT  = 4,
    parameter int ERR_WINDOW = 64,
    parameter int WATCHDOG   = 1024
) (
    input  logic            clk,
    input  logic            rst,
    rx_channel_init_if.slave bus
);
    localparam int AW = $clog2(ALIGN_CNT + 1);
    localparam int VW = $clog2(VERIFY_CNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int CW = $clog2(ERR_WINDOW + 1);
    localparam int WW = $clog2(WATCHDOG + 1);

    localparam logic [2:0] ST_RESET        = 3'd0;
    localparam logic [2:0] ST_INIT         = 3'd1;
    localparam logic [2:0] ST_BONDING      = 3'd2;
    localparam logic [2:0] ST_VERIFICATION = 3'd3;
    localparam logic [2:0] ST_READY        = 3'd4;

    localparam logic [2:0] OS_A = 3'd2;
    localparam logic [2:0] OS_V = 3'd3;

    localparam logic [AW-1:0] ALIGN_LAST  = AW'(ALIGN_CNT - 1);
    localparam logic [AW-1:0] ALIGN_ONE   = AW'(1);
    localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_CNT - 1);
    localparam logic [VW-1:0] VERIFY_ONE  = VW'(1);
    localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_LIMIT - 1);
    localparam logic [EW-1:0] ERR_ONE     = EW'(1);
    localparam logic [CW-1:0] CLEAN_LAST  = CW'(ERR_WINDOW - 1);
    localparam logic [CW-1:0] CLEAN_ONE   = CW'(1);
    localparam logic [WW-1:0] WD_LAST     = WW'(WATCHDOG - 1);
    localparam logic [WW-1:0] WD_ONE      = WW'(1);

    function automatic logic is_good(input logic v, input logic e, input logic [2:0] os);
        return v && !e && (os != 3'd0) && (os <= 3'd4);
    endfunction

    // Code errors dominate the word class, so any errored word is bad.
    function automatic logic is_bad(input logic v, input logic e, input logic [2:0] os);
        return v && (e || (os >= 3'd5));
    endfunction

    function automatic logic is_data(input logic v, input logic e, input logic [2:0] os);
        return v && !e && (os == 3'd0);
    endfunction

    logic [2:0]    state_r, state_s;
    logic [AW-1:0] align_r, align_s;
    logic [VW-1:0] verify_r, verify_s;
    logic [EW-1:0] err_r, err_s;
    logic [CW-1:0] clean_r, clean_s;
    logic [WW-1:0] wd_r, wd_s;
    logic          aligned_r, aligned_s;
    logic          bonded_r, bonded_s;
    logic          verified_r, verified_s;
    logic          up_r, up_s;
    logic          go_init_s;
    logic          good_s, bad_s, data_s;

    // Word classification of the current receive slot.
    always_comb begin
        good_s = is_good(bus.rx_os_valid, bus.rx_code_err, bus.rx_os);
        bad_s  = is_bad(bus.rx_os_valid, bus.rx_code_err, bus.rx_os);
        data_s = is_data(bus.rx_os_valid, bus.rx_code_err, bus.rx_os);
    end

    // Next-state and counter update; go_init_s overrides everything below.
    always_comb begin
        state_s    = state_r;
        align_s    = align_r;
        verify_s   = verify_r;
        err_s      = err_r;
        clean_s    = clean_r;
        wd_s       = wd_r;
        aligned_s  = aligned_r;
        bonded_s   = bonded_r;
        verified_s = verified_r;
        up_s       = up_r;
        go_init_s  = 1'b0;
        case (state_r)
            ST_RESET: go_init_s = 1'b1;
            ST_INIT: begin
                if (good_s) begin
                    if (align_r == ALIGN_LAST) begin
                        state_s   = ST_BONDING;
                        aligned_s = 1'b1;
                        align_s   = '0;
                        wd_s      = '0;
                    end else begin
                        align_s = align_r + ALIGN_ONE;
                    end
                end else if (bad_s || data_s) begin
                    align_s = '0;
                end else begin
                    align_s = align_r;
                end
            end
            ST_BONDING: begin
                if (bad_s || data_s) begin
                    go_init_s = 1'b1;
                end else if (good_s && (bus.rx_os == OS_A)) begin
                    state_s  = ST_VERIFICATION;
                    bonded_s = 1'b1;
                    wd_s     = '0;
                end else if (wd_r == WD_LAST) begin
                    go_init_s = 1'b1;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end
            ST_VERIFICATION: begin
                if (bad_s || data_s) begin
                    go_init_s = 1'b1;
                end else if (good_s && (bus.rx_os == OS_V)) begin
                    wd_s = '0;
                    if (verify_r == VERIFY_LAST) begin
                        state_s    = ST_READY;
                        verified_s = 1'b1;
                        up_s       = 1'b1;
                        verify_s   = '0;
                    end else begin
                        verify_s = verify_r + VERIFY_ONE;
                    end
                end else begin
                    if (good_s && (bus.rx_os == OS_A)) begin
                        verify_s = '0;
                    end else begin
                        verify_s = verify_r;
                    end
                    if (wd_r == WD_LAST) begin
                        go_init_s = 1'b1;
                    end else begin
                        wd_s = wd_r + WD_ONE;
                    end
                end
            end
            ST_READY: begin
                if (bad_s) begin
                    clean_s = '0;
                    if (err_r >= ERR_LAST) begin
                        go_init_s = 1'b1;
                    end else begin
                        err_s = err_r + ERR_ONE;
                    end
                end else if (bus.rx_os_valid) begin
                    // A full clean window forgives all earlier errors.
                    if (clean_r == CLEAN_LAST) begin
                        clean_s = '0;
                        err_s   = '0;
                    end else begin
                        clean_s = clean_r + CLEAN_ONE;
                    end
                end else begin
                    clean_s = clean_r;
                end
            end
            default: go_init_s = 1'b1;
        endcase
    end

    // State, counter and registered output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RESET;
            align_r    <= '0;
            verify_r   <= '0;
            err_r      <= '0;
            clean_r    <= '0;
            wd_r       <= '0;
            aligned_r  <= 1'b0;
            bonded_r   <= 1'b0;
            verified_r <= 1'b0;
            up_r       <= 1'b0;
        end else if (go_init_s) begin
            state_r    <= ST_INIT;
            align_r    <= '0;
            verify_r   <= '0;
            err_r      <= '0;
            clean_r    <= '0;
            wd_r       <= '0;
            aligned_r  <= 1'b0;
            bonded_r   <= 1'b0;
            verified_r <= 1'b0;
            up_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            align_r    <= align_s;
            verify_r   <= verify_s;
            err_r      <= err_s;
            clean_r    <= clean_s;
            wd_r       <= wd_s;
            aligned_r  <= aligned_s;
            bonded_r   <= bonded_s;
            verified_r <= verified_s;
            up_r       <= up_s;
        end
    end

    assign bus.state       = state_r;
    assign bus.rx_aligned  = aligned_r;
    assign bus.rx_bonded   = bonded_r;
    assign bus.rx_verified = verified_r;
    assign bus.channel_up  = up_r;
endmodule

// File: tb/tb_rx_channel_init.sv
// Bench for rx_channel_init: directed scenarios plus randomized words, all
// checked every cycle against a behavioural model of the init sequence.
module tb_rx_channel_init;
    localparam int ALIGN_CNT  = 8;
    localparam int VERIFY_CNT = 4;
    localparam int ERR_LIMIT  = 4;
    localparam int ERR_WINDOW = 64;
    localparam int WATCHDOG   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    rx_channel_init_if bus();

    rx_channel_init #(
        .ALIGN_CNT(ALIGN_CNT), .VERIFY_CNT(VERIFY_CNT), .ERR_LIMIT(ERR_LIMIT),
        .ERR_WINDOW(ERR_WINDOW), .WATCHDOG(WATCHDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase number plus plain integer counters.
    int m_st, m_align, m_ver, m_wd, m_err, m_clean;
    bit m_al, m_bo, m_ve, m_up;

    task automatic model_clear();
        m_align = 0; m_ver = 0; m_wd = 0; m_err = 0; m_clean = 0;
        m_al = 0; m_bo = 0; m_ve = 0; m_up = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_st = 0;
    endtask

    task automatic model_init();
        model_clear();
        m_st = 1;
    endtask

    task automatic model_step(input bit v, input bit [2:0] os, input bit e);
        bit good, bad, data;
        good = v && !e && (os >= 1) && (os <= 4);
        bad  = v && (e || (os >= 5));
        data = v && !e && (os == 0);
        case (m_st)
            0: model_init();
            1: begin
                if (good) begin
                    m_align++;
                    if (m_align == ALIGN_CNT) begin
                        m_st = 2; m_al = 1; m_align = 0; m_wd = 0;
                    end
                end else if (bad || data) m_align = 0;
            end
            2: begin
                if (bad || data) model_init();
                else if (good && os == 2) begin
                    m_st = 3; m_bo = 1; m_wd = 0;
                end else begin
                    m_wd++;
                    if (m_wd == WATCHDOG) model_init();
                end
            end
            3: begin
                if (bad || data) model_init();
                else if (good && os == 3) begin
                    m_ver++; m_wd = 0;
                    if (m_ver == VERIFY_CNT) begin
                        m_st = 4; m_ve = 1; m_up = 1; m_ver = 0;
                    end
                end else begin
                    if (good && os == 2) m_ver = 0;
                    m_wd++;
                    if (m_wd == WATCHDOG) model_init();
                end
            end
            4: begin
                if (bad) begin
                    m_clean = 0;
                    if (m_err < ERR_LIMIT) m_err++;
                    if (m_err >= ERR_LIMIT) model_init();
                end else if (v) begin
                    m_clean++;
                    if (m_clean >= ERR_WINDOW) begin
                        m_clean = 0; m_err = 0;
                    end
                end
            end
            default: model_init();
        endcase
    endtask

    // Every-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            n_checks++;
            if ({bus.state, bus.rx_aligned, bus.rx_bonded, bus.rx_verified, bus.channel_up} !==
                {3'(m_st), m_al, m_bo, m_ve, m_up}) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t: got state=%0d al/bo/ve/up=%b%b%b%b, want state=%0d %b%b%b%b",
                         $time, bus.state, bus.rx_aligned, bus.rx_bonded, bus.rx_verified, bus.channel_up,
                         m_st, m_al, m_bo, m_ve, m_up);
            end
        end
    end

    // Drive one word, let the DUT take it on the edge, advance the model.
    task automatic cyc(input bit v, input bit [2:0] os, input bit e);
        bus.rx_os_valid = v;
        bus.rx_os       = os;
        bus.rx_code_err = e;
        @(posedge clk);
        if (!rst) model_step(v, os, e);
        #1;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [2:0] st, input logic [3:0] flags);
        n_checks++;
        if ({bus.state, bus.rx_aligned, bus.rx_bonded, bus.rx_verified, bus.channel_up} !== {st, flags}) begin
            n_fail++;
            $display("FAIL %s dut: got state=%0d flags=%b%b%b%b, want state=%0d flags=%b",
                     name, bus.state, bus.rx_aligned, bus.rx_bonded, bus.rx_verified, bus.channel_up, st, flags);
        end
        n_checks++;
        if ({3'(m_st), m_al, m_bo, m_ve, m_up} !== {st, flags}) begin
            n_fail++;
            $display("FAIL %s model: got state=%0d flags=%b%b%b%b, want state=%0d flags=%b",
                     name, m_st, m_al, m_bo, m_ve, m_up, st, flags);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 3'd0, 1'b0);
    endtask

    task automatic bring_up();
        do_reset();
        repeat (ALIGN_CNT) cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);
        repeat (VERIFY_CNT) cyc(1'b1, 3'd3, 1'b0);
    endtask

    task automatic rand_word(output bit v, output bit [2:0] os, output bit e);
        int p;
        p  = $urandom_range(0, 99);
        v  = ($urandom_range(0, 99) < 93);
        e  = ($urandom_range(0, 199) == 0);
        if (m_st == 4)
            os = (p < 88) ? 3'd0 : (p < 97) ? 3'(1 + p % 4) : 3'(5 + p % 3);
        else if (m_st == 3)
            os = (p < 60) ? 3'd3 : (p < 80) ? 3'd1 : (p < 88) ? 3'd4 :
                 (p < 93) ? 3'd2 : (p < 97) ? 3'd0 : 3'(5 + p % 3);
        else
            os = (p < 50) ? 3'd1 : (p < 70) ? 3'd2 : (p < 85) ? 3'd3 :
                 (p < 92) ? 3'd4 : (p < 97) ? 3'd0 : 3'(5 + p % 3);
    endtask

    initial begin
        bit v, e;
        bit [2:0] os;
        bus.rx_os_valid = 1'b0;
        bus.rx_os       = 3'd0;
        bus.rx_code_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        lit("reset_held", 3'd0, 4'b0000);
        rst = 1'b0;
        cyc(1'b0, 3'd0, 1'b0);
        lit("init_after_release", 3'd1, 4'b0000);

        // Full bring-up sequence
        repeat (7) cyc(1'b1, 3'd1, 1'b0);
        lit("k7_not_aligned", 3'd1, 4'b0000);
        cyc(1'b1, 3'd1, 1'b0);
        lit("k8_aligned", 3'd2, 4'b1000);
        cyc(1'b1, 3'd2, 1'b0);
        lit("a_bonded", 3'd3, 4'b1100);
        repeat (3) cyc(1'b1, 3'd3, 1'b0);
        lit("v3_verifying", 3'd3, 4'b1100);
        cyc(1'b1, 3'd3, 1'b0);
        lit("v4_ready", 3'd4, 4'b1111);

        // Four spaced errors in READY
        repeat (3) begin
            cyc(1'b1, 3'd0, 1'b1);
            repeat (10) cyc(1'b1, 3'd0, 1'b0);
        end
        lit("ready_err3", 3'd4, 4'b1111);
        cyc(1'b1, 3'd0, 1'b1);
        lit("ready_err4_init", 3'd1, 4'b0000);

        // Align counter restart on a code error
        repeat (5) cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd1, 1'b1);
        repeat (7) cyc(1'b1, 3'd1, 1'b0);
        lit("realign_k7", 3'd1, 4'b0000);
        cyc(1'b1, 3'd1, 1'b0);
        lit("realign_k8", 3'd2, 4'b1000);
        cyc(1'b1, 3'd2, 1'b0);

        // /K/ holds the verify count
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        lit("vvkv_verifying", 3'd3, 4'b1100);
        cyc(1'b1, 3'd3, 1'b0);
        lit("vvkvv_ready", 3'd4, 4'b1111);

        // Error window forgiveness, then error count carried after it
        repeat (3) cyc(1'b1, 3'd6, 1'b0);
        repeat (ERR_WINDOW) cyc(1'b1, 3'd0, 1'b0);
        repeat (3) cyc(1'b1, 3'd5, 1'b0);
        lit("window_cleared", 3'd4, 4'b1111);
        cyc(1'b1, 3'd7, 1'b0);
        lit("window_then_err4", 3'd1, 4'b0000);

        // /A/ clears the verify count
        bring_up();
        lit("bringup_ready", 3'd4, 4'b1111);
        do_reset();
        repeat (ALIGN_CNT) cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        lit("vvav_verifying", 3'd3, 4'b1100);
        repeat (2) cyc(1'b1, 3'd3, 1'b0);
        lit("vvav_vv_verifying", 3'd3, 4'b1100);
        cyc(1'b1, 3'd3, 1'b0);
        lit("vvav_vvv_ready", 3'd4, 4'b1111);

        // Asynchronous reset between edges
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        lit("async_rst", 3'd0, 4'b0000);
        #1;
        rst = 1'b0;
        cyc(1'b0, 3'd0, 1'b0);
        lit("rst_release_init", 3'd1, 4'b0000);

        // Bonding watchdog
        repeat (ALIGN_CNT) cyc(1'b1, 3'd1, 1'b0);
        repeat (WATCHDOG - 1) cyc(1'b0, 3'd2, 1'b0);
        lit("wd_almost", 3'd2, 4'b1000);
        cyc(1'b0, 3'd2, 1'b0);
        lit("wd_expired", 3'd1, 4'b0000);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1999) == 0) do_reset();
            rand_word(v, os, e);
            cyc(v, os, e);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
